// File: rtl/mips_instr_encoder_loader.sv
// mips_instr_encoder_loader
//
// Boot-time program loader for the single-cycle MIPS core. The loader accepts
// symbolic instructions over a valid/ready handshake. It packs each one into a
// 32-bit MIPS word that uses the opcode/funct values the control decoder
// recognises, then writes the words one after another into instruction memory,
// starting at BASE_ADDR.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, finish       single-cycle pulses that open and close a load session
//   in_valid/in_ready   handshake for one symbolic instruction
//   in_mnem             mnemonic code (0..25 valid, 24 unassigned, 26..31 invalid)
//   in_rs/rt/rd/shamt   register and shift-amount fields
//   in_imm, in_target   immediate/branch offset and jump target fields
//   imem_we/addr/wdata  instruction-memory write port, one cycle after accept
//   count, full         words written this session, count == DEPTH
//   busy, done          session open / session closed
//   err_invalid         sticky flag: an invalid mnemonic was consumed

module mips_instr_encoder_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_mnem,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             busy,
  output logic             done,
  output logic             err_invalid
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  // Mnemonic codes as seen on in_mnem.
  typedef enum logic [4:0] {
    MnAdd    = 5'd0,
    MnSub    = 5'd1,
    MnSubu   = 5'd2,
    MnAnd    = 5'd3,
    MnOr     = 5'd4,
    MnXor    = 5'd5,
    MnNor    = 5'd6,
    MnSlt    = 5'd7,
    MnSll    = 5'd8,
    MnSrl    = 5'd9,
    MnJr     = 5'd10,
    MnAddi   = 5'd11,
    MnAddiu  = 5'd12,
    MnAndi   = 5'd13,
    MnOri    = 5'd14,
    MnXori   = 5'd15,
    MnSlti   = 5'd16,
    MnSltiu  = 5'd17,
    MnLw     = 5'd18,
    MnLb     = 5'd19,
    MnSw     = 5'd20,
    MnSb     = 5'd21,
    MnBeq    = 5'd22,
    MnBne    = 5'd23,
    MnRsvd24 = 5'd24,
    MnJ      = 5'd25
  } mnem_e;

  // ---------------------------------------------------------------------------
  // Field packing helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic        enc_valid;
  logic [31:0] enc_word;

  always_comb begin
    enc_valid = 1'b1;
    enc_word  = '0;
    case (in_mnem)
      // Plain R-type ALU ops: shamt is meaningless and is forced to zero.
      MnAdd:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b100000);
      MnSub:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b100010);
      MnSubu:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b100011);
      MnAnd:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b100100);
      MnOr:    enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b100101);
      MnXor:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b100110);
      MnNor:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b100111);
      MnSlt:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, 6'b101010);
      // Shifts take their source from rt and the amount from shamt; rs is unused.
      MnSll:   enc_word = pack_r(5'd0, in_rt, in_rd, in_shamt, 6'b000000);
      MnSrl:   enc_word = pack_r(5'd0, in_rt, in_rd, in_shamt, 6'b000010);
      // jr reads only rs.
      MnJr:    enc_word = pack_r(in_rs, 5'd0, 5'd0, 5'd0, 6'b001000);
      MnAddi:  enc_word = pack_i(6'b001000, in_rs, in_rt, in_imm);
      MnAddiu: enc_word = pack_i(6'b001001, in_rs, in_rt, in_imm);
      MnAndi:  enc_word = pack_i(6'b001100, in_rs, in_rt, in_imm);
      MnOri:   enc_word = pack_i(6'b001101, in_rs, in_rt, in_imm);
      MnXori:  enc_word = pack_i(6'b001110, in_rs, in_rt, in_imm);
      MnSlti:  enc_word = pack_i(6'b001010, in_rs, in_rt, in_imm);
      MnSltiu: enc_word = pack_i(6'b001011, in_rs, in_rt, in_imm);
      MnLw:    enc_word = pack_i(6'b100011, in_rs, in_rt, in_imm);
      MnLb:    enc_word = pack_i(6'b100000, in_rs, in_rt, in_imm);
      MnSw:    enc_word = pack_i(6'b101011, in_rs, in_rt, in_imm);
      MnSb:    enc_word = pack_i(6'b101000, in_rs, in_rt, in_imm);
      MnBeq:   enc_word = pack_i(6'b000100, in_rs, in_rt, in_imm);
      MnBne:   enc_word = pack_i(6'b000101, in_rs, in_rt, in_imm);
      MnJ:     enc_word = pack_j(6'b000010, in_target);
      // Code 24 has no instruction assigned, so it is rejected the same way
      // as 26..31.
      default: enc_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Session control and write port
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      next_addr_q;
  logic             imem_we_q;
  logic [31:0]      imem_addr_q;
  logic [31:0]      imem_wdata_q;
  logic             full_w;
  logic             accept;

  assign full_w = (count_q == CNT_W'(DEPTH));

  // finish gates ready so that an accept can never race the session close.
  assign in_ready = (state_q == StLoad) && !full_w && !finish;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      next_addr_q  <= BASE_ADDR;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted valid instruction.
      imem_we_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          // finish is ignored here; start opens a fresh session.
          if (start) begin
            state_q     <= StLoad;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            next_addr_q <= BASE_ADDR;
          end
        end
        StLoad: begin
          // start is ignored while loading, so finish always wins.
          if (finish) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          if (accept) begin
            if (enc_valid) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= next_addr_q;
              imem_wdata_q <= enc_word;
              next_addr_q  <= next_addr_q + 32'd4;
              count_q      <= count_q + CNT_W'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign count       = count_q;
  assign full        = full_w;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_invalid = err_q;

endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// Directed bench for mips_instr_encoder_loader with a 4-word instruction memory.
module tb_mips_instr_encoder_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             finish;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_mnem;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [4:0]       in_shamt;
  logic [15:0]      in_imm;
  logic [25:0]      in_target;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             busy;
  logic             done;
  logic             err_invalid;

  mips_instr_encoder_loader #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mnem    (in_mnem),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .done       (done),
    .err_invalid(err_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt);
    in_valid  = 1'b1;
    in_mnem   = mn;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0;
    #2;
    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_invalid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // add r3, r1, r2 (shamt input nonzero, must be dropped)
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(in_ready), 32'd1);
    check("t1_count0", 32'(count), 32'd0);
    present(5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'hFFFF, 26'h3FF_FFFF);
    tick(); in_valid = 1'b0;
    check("t1_we", 32'(imem_we), 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    check("t1_wdata", imem_wdata, 32'h0022_1820);
    check("t1_count", 32'(count), 32'd1);
    tick();
    check("t1_we_pulse", 32'(imem_we), 32'd0);
    finish = 1'b1; #1;
    check("t1_finish_ready", 32'(in_ready), 32'd0);
    tick(); finish = 1'b0;
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_off", 32'(busy), 32'd0);

    // lw r8, 4(r29) then sll r2, r2, 4 with stray rs
    start = 1'b1; tick(); start = 1'b0;
    check("t2_count0", 32'(count), 32'd0);
    check("t2_done_off", 32'(done), 32'd0);
    present(5'd18, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    tick();
    present(5'd8, 5'd7, 5'd2, 5'd2, 5'd4, 16'h0, 26'h0);
    check("t2_lw_we", 32'(imem_we), 32'd1);
    check("t2_lw_addr", imem_addr, 32'h0);
    check("t2_lw_wdata", imem_wdata, 32'h8FA8_0004);
    tick(); in_valid = 1'b0;
    check("t2_sll_we", 32'(imem_we), 32'd1);
    check("t2_sll_addr", imem_addr, 32'h4);
    check("t2_sll_wdata", imem_wdata, 32'h0002_1100);
    check("t2_count", 32'(count), 32'd2);

    // j 0x10, invalid code 28, then jr fills the memory
    present(5'd25, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1234, 26'h000_0010);
    tick(); in_valid = 1'b0;
    check("t3_j_we", 32'(imem_we), 32'd1);
    check("t3_j_addr", imem_addr, 32'h8);
    check("t3_j_wdata", imem_wdata, 32'h0800_0010);
    check("t3_j_count", 32'(count), 32'd3);
    present(5'd28, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    check("t3_inv_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("t3_inv_we", 32'(imem_we), 32'd0);
    check("t3_inv_err", 32'(err_invalid), 32'd1);
    check("t3_inv_count", 32'(count), 32'd3);
    present(5'd10, 5'd31, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
    tick();
    check("t3_jr_we", 32'(imem_we), 32'd1);
    check("t3_jr_addr", imem_addr, 32'hC);
    check("t3_jr_wdata", imem_wdata, 32'h03E0_0008);
    check("t3_full", 32'(full), 32'd1);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    tick(); in_valid = 1'b0;
    check("t3_held_we", 32'(imem_we), 32'd0);
    check("t3_held_count", 32'(count), 32'd4);
    finish = 1'b1; tick(); finish = 1'b0;
    check("t3_done", 32'(done), 32'd1);
    check("t3_err_kept", 32'(err_invalid), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    check("t3_err_clr", 32'(err_invalid), 32'd0);
    check("t3_count_clr", 32'(count), 32'd0);
    check("t3_full_clr", 32'(full), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);

    // Stream addi r1, r0, k with in_valid held high
    for (int k = 0; k < 4; k++) begin
      present(5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'(k), 26'h0);
      tick();
      check("t4_we", 32'(imem_we), 32'd1);
      check("t4_addr", imem_addr, 32'(4 * k));
      check("t4_wdata", imem_wdata, 32'h2001_0000 | 32'(k));
      check("t4_count", 32'(count), 32'(k + 1));
    end
    present(5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'd4, 26'h0);
    check("t4_full", 32'(full), 32'd1);
    check("t4_ready", 32'(in_ready), 32'd0);
    tick();
    check("t4_5th_we", 32'(imem_we), 32'd0);
    check("t4_5th_count", 32'(count), 32'd4);
    tick();
    check("t4_5th_we2", 32'(imem_we), 32'd0);
    check("t4_addr_hold", imem_addr, 32'hC);
    finish = 1'b1; tick(); finish = 1'b0; in_valid = 1'b0;
    check("t4_done", 32'(done), 32'd1);

    // start+finish in IDLE opens a session; in LOAD finish wins over start
    rst_n = 1'b0; #1;
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b1; finish = 1'b1; tick(); start = 1'b0; finish = 1'b0;
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_not_done", 32'(done), 32'd0);
    present(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    tick(); in_valid = 1'b0; start = 1'b1; finish = 1'b1; #1;
    check("t5_last_we", 32'(imem_we), 32'd1);
    check("t5_last_addr", imem_addr, 32'h0);
    check("t5_last_wdata", imem_wdata, 32'h0022_1825);
    check("t5_fin_ready", 32'(in_ready), 32'd0);
    tick(); start = 1'b0; finish = 1'b0;
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy_off", 32'(busy), 32'd0);
    check("t5_we_off", 32'(imem_we), 32'd0);
    check("t5_count", 32'(count), 32'd1);

    // Reset in the middle of a streaming load
    start = 1'b1; tick(); start = 1'b0;
    present(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    tick(); tick();
    check("t6_we", 32'(imem_we), 32'd1);
    check("t6_addr", imem_addr, 32'h4);
    check("t6_wdata", imem_wdata, 32'h0085_3022);
    check("t6_count", 32'(count), 32'd2);
    rst_n = 1'b0; #1;
    check("t6_rst_we", 32'(imem_we), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    check("t6_rst_addr", imem_addr, 32'h0);
    tick(); rst_n = 1'b1;
    tick();
    check("t6_post_we", 32'(imem_we), 32'd0);
    check("t6_post_busy", 32'(busy), 32'd0);
    check("t6_post_count", 32'(count), 32'd0);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
